// File: rtl/rob_cdb_receiver.sv
// Reorder-buffer completion/commit block: allocates in-order tags at dispatch,
// absorbs results from two CDB ports, and retires in program order through a
// valid/ready handshake to the register file.

// One ROB slot: busy/ready flags plus the destination register and result.
module rob_entry #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              alloc_i,
    input  logic [REG_W-1:0]  dest_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              retire_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic [REG_W-1:0]  dest_o,
    output logic [DATA_W-1:0] data_o
);
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-state: clear wins; alloc, write and retire never target the same
    // slot in one cycle (each requires a different busy/ready combination).
    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        dest_d  = dest_q;
        data_d  = data_q;
        if (clr_i) begin
            busy_d  = 1'b0;
            ready_d = 1'b0;
        end else begin
            if (alloc_i) begin
                busy_d  = 1'b1;
                ready_d = 1'b0;
                dest_d  = dest_i;
            end
            if (wr_i) begin
                ready_d = 1'b1;
                data_d  = data_i;
            end
            if (retire_i) begin
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        end
    end

    // Slot state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
        end
    end

    assign busy_o  = busy_q;
    assign ready_o = ready_q;
    assign dest_o  = dest_q;
    assign data_o  = data_q;
endmodule

module rob_cdb_receiver #(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb0_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [DATA_W-1:0] cdb0_data,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_data,
    input  logic              flush,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [REG_W-1:0]  commit_dest,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W:0]    count
);
    localparam int             DEPTH   = 1 << TAG_W;
    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic [DEPTH-1:0]             ent_busy;
    logic [DEPTH-1:0]             ent_ready;
    logic [DEPTH-1:0][REG_W-1:0]  ent_dest;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;

    logic alloc_fire, retire_fire, wr0, wr1;

    // Fire conditions; a write to a slot that is free or already complete is
    // dropped, and on a same-tag collision port 0 takes the slot.
    always_comb begin
        alloc_fire  = alloc_valid && alloc_ready && !flush;
        wr0         = cdb0_valid && ent_busy[cdb0_tag] && !ent_ready[cdb0_tag] && !flush;
        wr1         = cdb1_valid && ent_busy[cdb1_tag] && !ent_ready[cdb1_tag] && !flush
                      && !(cdb0_valid && (cdb0_tag == cdb1_tag));
        retire_fire = commit_valid && commit_ready && !flush;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        localparam logic [TAG_W-1:0] IDX = TAG_W'(i);
        logic hit0, hit1;
        assign hit0 = wr0 && (cdb0_tag == IDX);
        assign hit1 = wr1 && (cdb1_tag == IDX);
        rob_entry #(.DATA_W(DATA_W), .REG_W(REG_W)) u_ent (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (flush),
            .alloc_i  (alloc_fire && (tail_q == IDX)),
            .dest_i   (alloc_dest),
            .wr_i     (hit0 || hit1),
            .data_i   (hit0 ? cdb0_data : cdb1_data),
            .retire_i (retire_fire && (head_q == IDX)),
            .busy_o   (ent_busy[i]),
            .ready_o  (ent_ready[i]),
            .dest_o   (ent_dest[i]),
            .data_o   (ent_data[i])
        );
    end

    // Pointer/occupancy next-state; flush rewinds everything to empty.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire)  tail_d = tail_q + 1'b1;
            if (retire_fire) head_d = head_q + 1'b1;
            count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_fire);
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign alloc_ready  = (count_q != DEPTH_C);
    assign alloc_tag    = tail_q;
    assign count        = count_q;
    assign commit_valid = ent_busy[head_q] && ent_ready[head_q];
    assign commit_tag   = head_q;
    assign commit_dest  = ent_dest[head_q];
    assign commit_data  = ent_data[head_q];
endmodule

// File: tb/tb_rob_cdb_receiver.sv
// Directed bench for rob_cdb_receiver: inputs change 1 ns after the rising
// edge, outputs are checked before the next rising edge.
module tb_rob_cdb_receiver;
    logic        clk = 1'b0;
    logic        rst, alloc_valid, alloc_ready;
    logic [4:0]  alloc_dest, commit_dest;
    logic [2:0]  alloc_tag, cdb0_tag, cdb1_tag, commit_tag;
    logic        cdb0_valid, cdb1_valid, flush, commit_valid, commit_ready;
    logic [31:0] cdb0_data, cdb1_data, commit_data;
    logic [3:0]  count;

    int errs   = 0;
    int checks = 0;

    rob_cdb_receiver dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .flush(flush),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_tag(commit_tag), .commit_dest(commit_dest),
        .commit_data(commit_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; alloc_valid = 0; alloc_dest = 0;
        cdb0_valid = 0; cdb0_tag = 0; cdb0_data = 0;
        cdb1_valid = 0; cdb1_tag = 0; cdb1_data = 0;
        commit_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic alloc(input logic [4:0] d);
        alloc_valid = 1; alloc_dest = d;
        tick();
        alloc_valid = 0;
    endtask

    task automatic cdb0(input logic [2:0] t, input logic [31:0] d);
        cdb0_valid = 1; cdb0_tag = t; cdb0_data = d;
    endtask

    task automatic cdb1(input logic [2:0] t, input logic [31:0] d);
        cdb1_valid = 1; cdb1_tag = t; cdb1_data = d;
    endtask

    task automatic chk_commit(input string tag, input logic [2:0] t,
                              input logic [4:0] d, input logic [31:0] v);
        chk({tag, ".valid"}, commit_valid, 1);
        chk({tag, ".tag"},   commit_tag, t);
        chk({tag, ".dest"},  commit_dest, d);
        chk({tag, ".data"},  commit_data, v);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst.alloc_ready", alloc_ready, 1);
        chk("rst.alloc_tag", alloc_tag, 0);
        chk("rst.commit_valid", commit_valid, 0);
        chk("rst.commit_tag", commit_tag, 0);
        chk("rst.commit_dest", commit_dest, 0);
        chk("rst.commit_data", commit_data, 0);
        chk("rst.count", count, 0);

        // In-order allocate and retire
        alloc(1); alloc(2); alloc(3);
        chk("io.count3", count, 3);
        chk("io.alloc_tag3", alloc_tag, 3);
        chk("io.nocommit", commit_valid, 0);
        cdb0(0, 32'h11); commit_ready = 1;
        tick();
        chk_commit("io.c0", 0, 1, 32'h11);
        cdb0(1, 32'h22);
        tick();
        chk_commit("io.c1", 1, 2, 32'h22);
        cdb0(2, 32'h33);
        tick();
        chk_commit("io.c2", 2, 3, 32'h33);
        cdb0_valid = 0;
        tick();
        chk("io.count0", count, 0);
        chk("io.empty", commit_valid, 0);

        // Out-of-order completion
        do_reset();
        alloc(4); alloc(5);
        cdb1(1, 32'hBEEF); commit_ready = 1;
        tick();
        cdb1_valid = 0;
        chk("ooo.wait1", commit_valid, 0);
        tick();
        chk("ooo.wait2", commit_valid, 0);
        cdb0(0, 32'hAAAA);
        tick();
        cdb0_valid = 0;
        chk_commit("ooo.c0", 0, 4, 32'hAAAA);
        tick();
        chk_commit("ooo.c1", 1, 5, 32'hBEEF);
        tick();
        chk("ooo.count0", count, 0);

        // Full and wrap
        do_reset();
        for (int i = 0; i < 8; i++) alloc(5'(i + 16));
        chk("full.count", count, 8);
        chk("full.alloc_ready", alloc_ready, 0);
        chk("full.alloc_tag", alloc_tag, 0);
        alloc(31);
        chk("full.ignored_count", count, 8);
        chk("full.ignored_tag", alloc_tag, 0);
        cdb0(0, 32'h100);
        tick();
        cdb0_valid = 0;
        chk_commit("full.head", 0, 16, 32'h100);
        commit_ready = 1;
        tick();
        commit_ready = 0;
        chk("wrap.count7", count, 7);
        chk("wrap.alloc_ready", alloc_ready, 1);
        chk("wrap.alloc_tag", alloc_tag, 0);
        alloc(9);
        chk("wrap.count8", count, 8);
        chk("wrap.alloc_ready0", alloc_ready, 0);
        chk("wrap.tail", alloc_tag, 1);
        chk("wrap.head", commit_tag, 1);

        // Dual-CDB collision, stale write, distinct-tag pair
        do_reset();
        alloc(10); alloc(11); alloc(12); alloc(13);
        cdb0(3, 32'h1); cdb1(3, 32'h2);
        tick();
        cdb1_valid = 0;
        cdb0(3, 32'h9);
        tick();
        cdb0(0, 32'hA0); cdb1(1, 32'hB1);
        tick();
        cdb1_valid = 0;
        cdb0(2, 32'hC2);
        tick();
        cdb0_valid = 0; commit_ready = 1;
        chk_commit("col.c0", 0, 10, 32'hA0);
        tick();
        chk_commit("col.c1", 1, 11, 32'hB1);
        tick();
        chk_commit("col.c2", 2, 12, 32'hC2);
        tick();
        chk_commit("col.c3", 3, 13, 32'h1);
        tick();
        chk("col.count0", count, 0);

        // Backpressure: head held while a younger entry completes
        do_reset();
        alloc(7); alloc(8);
        cdb0(0, 32'h55);
        tick();
        cdb0_valid = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) cdb1(1, 32'h66);
            chk_commit("bp.hold", 0, 7, 32'h55);
            tick();
            cdb1_valid = 0;
        end
        chk("bp.count2", count, 2);
        commit_ready = 1;
        tick();
        commit_ready = 0;
        chk("bp.count1", count, 1);
        chk_commit("bp.next", 1, 8, 32'h66);

        // Flush with concurrent alloc/cdb/retire
        do_reset();
        for (int i = 0; i < 5; i++) alloc(5'(i + 1));
        cdb0(0, 32'h77);
        tick();
        chk("fl.pending", commit_valid, 1);
        flush = 1; alloc_valid = 1; alloc_dest = 5'd20; cdb0(1, 32'h88); commit_ready = 1;
        tick();
        idle();
        chk("fl.count", count, 0);
        chk("fl.alloc_tag", alloc_tag, 0);
        chk("fl.commit_valid", commit_valid, 0);
        chk("fl.alloc_ready", alloc_ready, 1);
        tick();
        chk("fl.still_empty", commit_valid, 0);

        // Same setup, reset instead of flush
        for (int i = 0; i < 5; i++) alloc(5'(i + 1));
        cdb0(0, 32'h77);
        tick();
        chk("rs.pending", commit_valid, 1);
        rst = 1; alloc_valid = 1; alloc_dest = 5'd20; cdb0(1, 32'h88); commit_ready = 1;
        tick();
        idle();
        chk("rs.count", count, 0);
        chk("rs.alloc_tag", alloc_tag, 0);
        chk("rs.commit_valid", commit_valid, 0);
        chk("rs.alloc_ready", alloc_ready, 1);
        chk("rs.commit_dest", commit_dest, 0);
        chk("rs.commit_data", commit_data, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
